// File: rtl/hilo_mult_pkg.sv
// Shared op encodings, FSM state type and helpers for the HI/LO multiply unit.
package hilo_mult_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_MULT = 5'd16;
    localparam logic [4:0] ALU_MUL  = 5'd17;
    localparam logic [4:0] ALU_MFHI = 5'd18;
    localparam logic [4:0] ALU_MFLO = 5'd19;
    localparam logic [4:0] ALU_MTHI = 5'd20;
    localparam logic [4:0] ALU_MTLO = 5'd21;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } hilo_state_e;

    // 0x80000000 maps to itself, which is the correct magnitude when read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic is_hilo_op(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_MUL)  || (op == ALU_MFHI) ||
               (op == ALU_MFLO) || (op == ALU_MTHI) || (op == ALU_MTLO);
    endfunction

endpackage

// File: rtl/hilo_mult_if.sv
// EX-stage <-> HI/LO multiply unit signal bundle.
interface hilo_mult_if #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 5
);
    logic               op_valid;
    logic [ALUOP_W-1:0] aluop;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic               flush;
    logic               stall;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_valid;
    logic               busy;
    logic [DATA_W-1:0]  hi;
    logic [DATA_W-1:0]  lo;

    modport master (
        output op_valid, aluop, rs_data, rt_data, flush,
        input  stall, rd_data, rd_valid, busy, hi, lo
    );

    modport slave (
        input  op_valid, aluop, rs_data, rt_data, flush,
        output stall, rd_data, rd_valid, busy, hi, lo
    );
endinterface

// File: rtl/hilo_mult_unit_core.sv
// Iterative unsigned shift-add multiplier on operand magnitudes, sign applied at the output.
module mult_iter_core
    import hilo_mult_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        kill,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [63:0] product
);
    localparam int N_ITER = 32 / BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(N_ITER);

    logic [63:0]      mcand_q;
    logic [31:0]      mplier_q;
    logic [63:0]      acc_q;
    logic [63:0]      partial;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q;
    logic             running_q;

    // Multiplicand and multiplier shift each iteration, so only the low bits are inspected.
    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) partial = partial + (mcand_q << j);
        end
    end

    assign done    = running_q && (cnt_q == CNT_W'(N_ITER - 1));
    assign product = sign_q ? (~acc_q + 64'd1) : acc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            running_q <= 1'b0;
        end else if (start) begin
            mcand_q   <= {32'd0, abs32(a)};
            mplier_q  <= abs32(b);
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= a[31] ^ b[31];
            running_q <= 1'b1;
        end else if (kill) begin
            running_q <= 1'b0;
        end else if (running_q) begin
            acc_q    <= acc_q + partial;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            cnt_q    <= cnt_q + 1'b1;
            if (done) running_q <= 1'b0;
        end
    end
endmodule

// File: rtl/hilo_mult_unit.sv
// EX-stage HI/LO unit: owns HI/LO, sequences the iterative multiplier and stalls the pipe.
//   state  | meaning
//   S_IDLE | accept MTHI/MTLO/MFHI/MFLO directly; MULT/MUL starts the core
//   S_RUN  | core iterating, stall held high
//   S_DONE | result cycle: MULT writes HI/LO, MUL drives rd_data; stall released
module hilo_mult_unit
    import hilo_mult_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ALUOP_W        = 5,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    hilo_mult_if.slave   bus
);
    hilo_state_e        state_q, state_d;
    logic [DATA_W-1:0]  hi_q, lo_q, hi_d, lo_d;
    logic [ALUOP_W-1:0] op;
    logic               hi_we, lo_we, kind_mul_q;
    logic               start, kill, core_done;
    logic [63:0]        product;
    logic               stall, busy, rd_valid;
    logic [DATA_W-1:0]  rd_data;

    assign op = bus.aluop;

    mult_iter_core #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_core (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .kill    (kill),
        .a       (bus.rs_data),
        .b       (bus.rt_data),
        .done    (core_done),
        .product (product)
    );

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        busy     = 1'b0;
        rd_valid = 1'b0;
        rd_data  = '0;
        start    = 1'b0;
        kill     = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid && is_hilo_op(op)) begin
                    case (op)
                        ALU_MTHI: begin
                            hi_we = !bus.flush;
                            hi_d  = bus.rs_data;
                        end
                        ALU_MTLO: begin
                            lo_we = !bus.flush;
                            lo_d  = bus.rs_data;
                        end
                        ALU_MFHI: begin
                            rd_data  = hi_q;
                            rd_valid = 1'b1;
                        end
                        ALU_MFLO: begin
                            rd_data  = lo_q;
                            rd_valid = 1'b1;
                        end
                        default: begin
                            stall = 1'b1;
                            if (!bus.flush) begin
                                start   = 1'b1;
                                state_d = S_RUN;
                            end
                        end
                    endcase
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (bus.flush) begin
                    kill    = 1'b1;
                    state_d = S_IDLE;
                end else if (core_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    if (kind_mul_q) begin
                        rd_data  = product[DATA_W-1:0];
                        rd_valid = 1'b1;
                    end else begin
                        hi_we = 1'b1;
                        lo_we = 1'b1;
                        hi_d  = product[63:32];
                        lo_d  = product[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            kind_mul_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hi_we) hi_q <= hi_d;
            if (lo_we) lo_q <= lo_d;
            if (start) kind_mul_q <= (op == ALU_MUL);
        end
    end

    assign bus.stall    = stall;
    assign bus.busy     = busy;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_data;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit: HI/LO moves, signed MULT/MUL, mid-run ops, flush and reset.
module tb_hilo_mult_unit;
    import hilo_mult_pkg::*;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   n;

    hilo_mult_if #(.DATA_W(32), .ALUOP_W(5)) bus ();

    hilo_mult_unit #(.DATA_W(32), .ALUOP_W(5), .BITS_PER_CYCLE(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = v;
        bus.aluop    = op;
        bus.rs_data  = a;
        bus.rt_data  = b;
    endtask

    // Issue a single-cycle op, then return the bus to idle.
    task automatic simple(input logic [4:0] op, input logic [31:0] a);
        @(negedge clock); drive(1'b1, op, a, 32'd0);
        @(negedge clock); drive(1'b0, ALU_ADD, 32'd0, 32'd0); #1;
    endtask

    // Hold a multiply on the bus until stall drops; returns in the DONE cycle with n = stall-high cycles.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int sw_at, input logic [4:0] sw_op, output int cnt);
        @(negedge clock); drive(1'b1, op, a, b); #1;
        cnt = 0;
        while (bus.stall === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == sw_at) bus.aluop = sw_op;
            @(negedge clock); #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, ALU_ADD, 32'd0, 32'd0);
        #2;
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        @(negedge clock); reset_n = 1'b1;

        @(negedge clock); drive(1'b1, ALU_MTHI, 32'h0000_1234, 32'd0); #1;
        check("mthi_stall", bus.stall, 0);
        check("mthi_rd_valid", bus.rd_valid, 0);
        @(negedge clock); drive(1'b1, ALU_MFHI, 32'd0, 32'd0); #1;
        check("mfhi_data", bus.rd_data, 64'h1234);
        check("mfhi_valid", bus.rd_valid, 1);
        check("mfhi_stall", bus.stall, 0);
        check("mfhi_lo", bus.lo, 0);

        issue(ALU_MULT, 32'd7, 32'hFFFF_FFFD, 0, ALU_MULT, n);
        check("mult_neg_stall_cycles", 64'(n), 33);
        check("mult_neg_done_rd_valid", bus.rd_valid, 0);
        check("mult_neg_done_busy", bus.busy, 0);
        @(negedge clock); drive(1'b0, ALU_ADD, 32'd0, 32'd0); #1;
        check("mult_neg_hi", bus.hi, 64'hFFFF_FFFF);
        check("mult_neg_lo", bus.lo, 64'hFFFF_FFEB);
        check("mult_neg_busy_after", bus.busy, 0);

        issue(ALU_MULT, 32'h8000_0000, 32'h8000_0000, 0, ALU_MULT, n);
        check("mult_min_cycles", 64'(n), 33);
        @(negedge clock); drive(1'b0, ALU_ADD, 32'd0, 32'd0); #1;
        check("mult_min_hi", bus.hi, 64'h4000_0000);
        check("mult_min_lo", bus.lo, 64'h0);

        issue(ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, ALU_MULT, n);
        @(negedge clock); drive(1'b0, ALU_ADD, 32'd0, 32'd0); #1;
        check("mult_m1_hi", bus.hi, 64'h0);
        check("mult_m1_lo", bus.lo, 64'h1);

        simple(ALU_MTHI, 32'h0000_AAAA);
        simple(ALU_MTLO, 32'h0000_5555);
        issue(ALU_MUL, 32'd100, 32'd200, 0, ALU_MUL, n);
        check("mul_cycles", 64'(n), 33);
        check("mul_rd_data", bus.rd_data, 64'h4E20);
        check("mul_rd_valid", bus.rd_valid, 1);
        check("mul_stall_done", bus.stall, 0);
        @(negedge clock); drive(1'b0, ALU_ADD, 32'd0, 32'd0); #1;
        check("mul_hi_kept", bus.hi, 64'hAAAA);
        check("mul_lo_kept", bus.lo, 64'h5555);
        check("mul_rd_valid_after", bus.rd_valid, 0);

        issue(ALU_MUL, 32'hFFFF_FFFB, 32'd6, 0, ALU_MUL, n);
        check("mul_neg_rd_data", bus.rd_data, 64'hFFFF_FFE2);
        @(negedge clock); drive(1'b0, ALU_ADD, 32'd0, 32'd0); #1;

        issue(ALU_MULT, 32'd5, 32'd6, 11, ALU_MFLO, n);
        check("mflo_held_cycles", 64'(n), 33);
        check("mflo_held_done_rd_valid", bus.rd_valid, 0);
        @(negedge clock); #1;
        check("mflo_after_data", bus.rd_data, 64'h1E);
        check("mflo_after_valid", bus.rd_valid, 1);
        check("mflo_after_hi", bus.hi, 64'h0);

        simple(ALU_MTHI, 32'h0000_0077);
        @(negedge clock); drive(1'b1, ALU_MULT, 32'd9, 32'd9); #1;
        repeat (13) @(negedge clock);
        #1;
        check("flush_run_busy", bus.busy, 1);
        bus.flush = 1'b1;
        @(negedge clock); bus.flush = 1'b0; drive(1'b0, ALU_ADD, 32'd0, 32'd0); #1;
        check("flush_busy", bus.busy, 0);
        check("flush_stall", bus.stall, 0);
        check("flush_hi", bus.hi, 64'h77);
        check("flush_lo", bus.lo, 64'h1E);
        repeat (40) @(negedge clock);
        #1;
        check("flush_lo_later", bus.lo, 64'h1E);

        issue(ALU_MULT, 32'd2, 32'd3, 0, ALU_MULT, n);
        bus.flush = 1'b1; #1;
        check("flush_done_rd_valid", bus.rd_valid, 0);
        @(negedge clock); bus.flush = 1'b0; drive(1'b0, ALU_ADD, 32'd0, 32'd0); #1;
        check("flush_done_lo", bus.lo, 64'h1E);

        @(negedge clock); drive(1'b1, ALU_MTHI, 32'h0000_DEAD, 32'd0); bus.flush = 1'b1;
        @(negedge clock); drive(1'b0, ALU_ADD, 32'd0, 32'd0); bus.flush = 1'b0; #1;
        check("flush_idle_mthi", bus.hi, 64'h77);

        @(negedge clock); drive(1'b1, ALU_MULT, 32'd3, 32'd4);
        repeat (6) @(negedge clock);
        #1;
        drive(1'b0, ALU_ADD, 32'd0, 32'd0);
        reset_n = 1'b0; #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_stall", bus.stall, 0);
        check("midrst_rd_valid", bus.rd_valid, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        @(negedge clock); reset_n = 1'b1;

        issue(ALU_MULT, 32'd3, 32'd4, 0, ALU_MULT, n);
        check("post_rst_cycles", 64'(n), 33);
        @(negedge clock); drive(1'b0, ALU_ADD, 32'd0, 32'd0); #1;
        check("post_rst_lo", bus.lo, 64'hC);
        check("post_rst_hi", bus.hi, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- EX-stage multiply unit that sits directly downstream of the ALU-op decoder and executes its HI/LO class ops: ALU_MULT, ALU_MUL, ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO.
- Owns the architectural HI/LO registers and runs an iterative signed shift-add multiplier.
- Asserts stall back to the pipeline while a HI/LO-dependent op cannot complete.
- The ALU ignores these ops; the EX result mux selects rd_data when rd_valid=1.

Parameters:
- DATA_W, 32, operand/HI/LO width (only 32 supported).
- ALUOP_W, 5, width of decoded ALU op.
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal 1, 2, 4; N_ITER = DATA_W/BITS_PER_CYCLE.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- op_valid  in  1  EX holds a valid instruction this cycle.
- aluop  in  ALUOP_W  decoded op, using the shared Aluop.v encodings.
- rs_data  in  DATA_W  operand A (MTHI/MTLO source).
- rt_data  in  DATA_W  operand B.
- flush  in  1  kill the in-flight op (exception/branch squash).
- stall  out  1  hold EX and upstream stages this cycle.
- rd_data  out  DATA_W  GPR result for MFHI/MFLO/MUL.
- rd_valid  out  1  rd_data is valid this cycle.
- busy  out  1  multiplier iterating.
- hi  out  DATA_W  architectural HI.
- lo  out  DATA_W  architectural LO.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; hi=lo=0; busy=0; stall=0; rd_valid=0; rd_data=0; iteration counter=0.
- hilo_op = op_valid & aluop ∈ {MULT, MUL, MFHI, MFLO, MTHI, MTLO}. Other ops: outputs idle and no state change.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - MTHI/MTLO: hi (resp. lo) ← rs_data at the next edge; stall=0; rd_valid=0.
  - MFHI/MFLO: combinational rd_data=hi (resp. lo); rd_valid=1 in the same cycle; stall=0.
  - MULT/MUL:
    - Latch |rs_data|, |rt_data|, sign = rs[31]^rt[31], and kind (MULT/MUL).
    - Clear the 64-bit accumulator and the counter; go to RUN.
    - stall=1 combinationally in the accept cycle.
- RUN:
  - Each cycle, add the multiplicand shifted by the counter position for each set bit among the next BITS_PER_CYCLE multiplier bits.
  - counter += 1; when counter == N_ITER-1, go to DONE.
  - busy=1; stall=1.
- DONE (one cycle):
  - product = sign ? -acc : acc (64-bit two's complement).
  - MULT: hi←product[63:32], lo←product[31:0] at the edge leaving DONE; rd_valid=0.
  - MUL: rd_data=product[31:0], rd_valid=1; HI/LO unchanged.
  - stall=0 in DONE so EX retires the held instruction; return to IDLE.
- Latency: accept cycle, then N_ITER RUN cycles, then DONE, for stall-high cycles = N_ITER+1.
  - With default parameters: 33 stall cycles; result in cycle 34 after accept.
- Abs of 0x80000000 is 0x80000000 treated as unsigned 32-bit; the accumulator is 64-bit unsigned, so there is no overflow.
- Any hilo_op presented while busy keeps stall=1; the held op is re-evaluated in IDLE/DONE, with no queueing.
  - The op is held in EX under stall, so the first accept is unique; the unit does not re-accept a MULT/MUL in its DONE cycle.
- flush:
  - In RUN or the accept cycle: go to IDLE next edge; HI/LO untouched; busy=0 next cycle; rd_valid=0.
  - Flush in DONE suppresses both the HI/LO write and rd_valid.
  - Flush in IDLE blocks MTHI/MTLO writes that cycle.
- Mid-operation reset: asynchronously returns to the reset state; the partial product is discarded.

Decomposition:
- Op encodings and widths come from the shared Aluop.v and Opcode.v include headers; no new constants are added.
- The FSM state encodings (IDLE/RUN/DONE) are added to a shared header hilo_defs.v.
- Natural sub-module: mult_iter_core, which handles the abs/iterate/negate datapath.
  - Handshake: start, a, b, done, product[63:0].
  - hilo_mult_unit keeps the FSM control, HI/LO registers, stall, and the forwarding mux.

Test Plan:
- Reset, then MTHI rs=0x00001234 and next cycle MFHI → rd_data=0x00001234, rd_valid=1, stall=0, lo=0.
- MULT rs=7, rt=0xFFFFFFFD (-3) → stall high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low afterward.
- MULT rs=rt=0x80000000 → hi=0x40000000, lo=0x00000000.
- MUL rs=100, rt=200 with hi/lo pre-set to 0xAAAA/0x5555 → rd_data=20000 (0x4E20), rd_valid=1 in the DONE cycle; hi/lo unchanged.
- MULT 5×6 in progress, MFLO presented at RUN cycle 10 → stall stays 1 until DONE; next IDLE cycle MFLO returns 0x0000001E.
- MULT in progress, flush at RUN cycle 12 → busy=0 next cycle, hi/lo retain prior values. Repeat with reset_n pulsed low mid-RUN → all outputs 0 immediately.
